clk_enable_gen: RTL and testbench

//  Fabric clock-enable generator with NUM_CH independent channels, each an integer divider with a phase offset.

---
 rtl/clk_enable_gen.sv | 141 ++++++++++++++
 tb/tb_clk_enable_gen.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_enable_gen.sv
// Multi-channel clock-enable generator: per-channel integer divider with phase offset,
// runtime reconfiguration through a valid/ready port and PLL-style lock/relock.
`timescale 1ns/1ps

module clk_enable_gen #(
    parameter int unsigned             NUM_CH     = 5,
    parameter int unsigned             CNT_W      = 16,
    parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT   = {NUM_CH{CNT_W'(1)}},
    parameter logic [NUM_CH*CNT_W-1:0] PHASE_INIT = '0,
    parameter int unsigned             LOCK_DELAY = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [3:0]        cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic [CNT_W-1:0]  cfg_phase,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] ce,
    output logic [NUM_CH-1:0] clk_o,
    output logic              locked
);

    localparam int unsigned LCK_W = (LOCK_DELAY > 1) ? $clog2(LOCK_DELAY) : 1;

    typedef enum logic {WARM, RUN} state_t;

    state_t             state_q, state_d;
    logic [LCK_W-1:0]   lock_q, lock_d;
    logic [CNT_W-1:0]   div_q   [NUM_CH];
    logic [CNT_W-1:0]   div_d   [NUM_CH];
    logic [CNT_W-1:0]   phase_q [NUM_CH];
    logic [CNT_W-1:0]   phase_d [NUM_CH];
    logic [CNT_W-1:0]   cnt_q   [NUM_CH];
    logic [CNT_W-1:0]   cnt_d   [NUM_CH];
    logic [CNT_W-1:0]   pos     [NUM_CH];
    logic [CNT_W:0]     half    [NUM_CH];
    logic [NUM_CH-1:0]  ce_q, ce_d;
    logic [NUM_CH-1:0]  clk_o_q, clk_o_d;
    logic               locked_q, locked_d;
    logic               ready_q, ready_d;
    logic               err_q, err_d;
    logic               cfg_fire_c;
    logic               cfg_bad_c;

    assign cfg_fire_c = cfg_valid & ready_q;
    assign cfg_bad_c  = ({1'b0, cfg_ch} >= 5'(NUM_CH)) || (cfg_div == '0) || (cfg_phase >= cfg_div);

    assign cfg_ready = ready_q;
    assign cfg_err   = err_q;
    assign ce        = ce_q;
    assign clk_o     = clk_o_q;
    assign locked    = locked_q;

    // Next-state, configuration update, counters and registered channel outputs
    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        div_d   = div_q;
        phase_d = phase_q;
        err_d   = 1'b0;

        case (state_q)
            WARM: begin
                if (lock_q == LCK_W'(LOCK_DELAY - 1)) begin
                    state_d = RUN;
                    lock_d  = '0;
                end else begin
                    lock_d = lock_q + LCK_W'(1);
                end
            end
            RUN: begin
                if (cfg_fire_c) begin
                    if (cfg_bad_c) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = WARM;
                        lock_d  = '0;
                        for (int unsigned i = 0; i < NUM_CH; i++) begin
                            if (cfg_ch == 4'(i)) begin
                                div_d[i]   = cfg_div;
                                phase_d[i] = cfg_phase;
                            end
                        end
                    end
                end
            end
            default: state_d = WARM;
        endcase

        // Counters only advance across consecutive RUN cycles; entry into RUN starts all at 0
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (state_q == RUN && state_d == RUN) begin
                cnt_d[i] = (cnt_q[i] == div_q[i] - CNT_W'(1)) ? '0 : cnt_q[i] + CNT_W'(1);
            end else begin
                cnt_d[i] = '0;
            end
            // cnt and phase are both below div, so the modular difference fits in CNT_W bits
            pos[i]  = (cnt_d[i] >= phase_d[i]) ? cnt_d[i] - phase_d[i]
                                               : cnt_d[i] + div_d[i] - phase_d[i];
            half[i] = ({1'b0, div_d[i]} + (CNT_W + 1)'(1)) >> 1;
            ce_d[i]    = (state_d == RUN) && (cnt_d[i] == phase_d[i]);
            clk_o_d[i] = (state_d == RUN) && ({1'b0, pos[i]} < half[i]);
        end

        locked_d = (state_d == RUN);
        ready_d  = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= WARM;
            lock_q   <= '0;
            ce_q     <= '0;
            clk_o_q  <= '0;
            locked_q <= 1'b0;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                div_q[i]   <= DIV_INIT[i*CNT_W +: CNT_W];
                phase_q[i] <= PHASE_INIT[i*CNT_W +: CNT_W];
                cnt_q[i]   <= '0;
            end
        end else begin
            state_q  <= state_d;
            lock_q   <= lock_d;
            ce_q     <= ce_d;
            clk_o_q  <= clk_o_d;
            locked_q <= locked_d;
            ready_q  <= ready_d;
            err_q    <= err_d;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                div_q[i]   <= div_d[i];
                phase_q[i] <= phase_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

endmodule

// File: tb/tb_clk_enable_gen.sv
// Directed bench for clk_enable_gen: 3 channels, divs {4,6,8}, phases {0,2,4}, lock delay 4.
`timescale 1ns/1ps

module tb_clk_enable_gen;

    logic       clk       = 1'b0;
    logic       reset_n   = 1'b1;
    logic       cfg_valid = 1'b0;
    logic [3:0] cfg_ch    = '0;
    logic [7:0] cfg_div   = '0;
    logic [7:0] cfg_phase = '0;
    logic       cfg_ready;
    logic       cfg_err;
    logic       locked;
    logic [2:0] ce;
    logic [2:0] clk_o;

    int checks = 0;
    int errors = 0;
    int k      = 0;

    // Expected 12-cycle windows after lock, leftmost bit = first locked cycle
    logic [11:0] ce0_def = 12'b100010001000;
    logic [11:0] ce1_def = 12'b001000001000;
    logic [11:0] ce2_def = 12'b000010000000;
    logic [11:0] co0_def = 12'b110011001100;
    logic [11:0] co1_def = 12'b001110001110;
    logic [11:0] co2_def = 12'b000011110000;
    logic [11:0] ce1_d5  = 12'b100001000010;
    logic [11:0] co1_d5  = 12'b111001110011;
    logic [9:0]  lk_held = 10'b0000100001;

    clk_enable_gen #(
        .NUM_CH    (3),
        .CNT_W     (8),
        .DIV_INIT  ({8'd8, 8'd6, 8'd4}),
        .PHASE_INIT({8'd4, 8'd2, 8'd0}),
        .LOCK_DELAY(4)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_ch   (cfg_ch),
        .cfg_div  (cfg_div),
        .cfg_phase(cfg_phase),
        .cfg_err  (cfg_err),
        .ce       (ce),
        .clk_o    (clk_o),
        .locked   (locked)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1 reset_n = 1'b0;
        #2;
        checks++;
        if ({locked, cfg_ready, cfg_err, ce, clk_o} !== 9'b0) begin
            errors++;
            $display("FAIL reset_state got %b want 000000000", {locked, cfg_ready, cfg_err, ce, clk_o});
        end
        tick();
        tick();
        reset_n = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            tick();
            checks++;
            if ({locked, cfg_ready} !== {2{n == 4}}) begin
                errors++;
                $display("FAIL reset_lock n=%0d got %b want %b", n, {locked, cfg_ready}, {2{n == 4}});
            end
            if (n < 4) begin
                checks++;
                if ({ce, clk_o} !== 6'b0) begin
                    errors++;
                    $display("FAIL reset_warm_out n=%0d got %b want 000000", n, {ce, clk_o});
                end
            end
        end
    endtask

    task automatic test_default_phases();
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (ce !== {ce2_def[11-i], ce1_def[11-i], ce0_def[11-i]}) begin
                errors++;
                $display("FAIL default_ce k=%0d got %b want %b", i, ce,
                         {ce2_def[11-i], ce1_def[11-i], ce0_def[11-i]});
            end
            checks++;
            if (clk_o !== {co2_def[11-i], co1_def[11-i], co0_def[11-i]}) begin
                errors++;
                $display("FAIL default_clk_o k=%0d got %b want %b", i, clk_o,
                         {co2_def[11-i], co1_def[11-i], co0_def[11-i]});
            end
            tick();
        end
    endtask

    task automatic test_reconfig();
        cfg_ch    = 4'd1;
        cfg_div   = 8'd5;
        cfg_phase = 8'd0;
        cfg_valid = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            tick();
            cfg_valid = 1'b0;
            checks++;
            if ({locked, cfg_ready, cfg_err} !== {{2{n == 5}}, 1'b0}) begin
                errors++;
                $display("FAIL reconfig_lock n=%0d got %b want %b", n, {locked, cfg_ready, cfg_err},
                         {{2{n == 5}}, 1'b0});
            end
            if (n < 5) begin
                checks++;
                if ({ce, clk_o} !== 6'b0) begin
                    errors++;
                    $display("FAIL reconfig_warm_out n=%0d got %b want 000000", n, {ce, clk_o});
                end
            end
        end
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (ce !== {ce2_def[11-i], ce1_d5[11-i], ce0_def[11-i]}) begin
                errors++;
                $display("FAIL reconfig_ce k=%0d got %b want %b", i, ce,
                         {ce2_def[11-i], ce1_d5[11-i], ce0_def[11-i]});
            end
            checks++;
            if (clk_o !== {co2_def[11-i], co1_d5[11-i], co0_def[11-i]}) begin
                errors++;
                $display("FAIL reconfig_clk_o k=%0d got %b want %b", i, clk_o,
                         {co2_def[11-i], co1_d5[11-i], co0_def[11-i]});
            end
            tick();
        end
        k = 12;
    endtask

    task automatic test_errors();
        logic [3:0] chs [3] = '{4'd1, 4'd1, 4'd3};
        logic [7:0] dvs [3] = '{8'd0, 8'd6, 8'd4};
        logic [7:0] phs [3] = '{8'd0, 8'd6, 8'd0};
        logic [2:0] exp_ce;
        for (int t = 0; t < 3; t++) begin
            cfg_ch    = chs[t];
            cfg_div   = dvs[t];
            cfg_phase = phs[t];
            cfg_valid = 1'b1;
            for (int p = 0; p < 2; p++) begin
                tick();
                k++;
                cfg_valid = 1'b0;
                exp_ce = {(k % 8) == 4, (k % 5) == 0, (k % 4) == 0};
                checks++;
                if ({cfg_err, locked, cfg_ready} !== {p == 0, 2'b11}) begin
                    errors++;
                    $display("FAIL cfg_err t=%0d p=%0d got %b want %b", t, p,
                             {cfg_err, locked, cfg_ready}, {p == 0, 2'b11});
                end
                checks++;
                if (ce !== exp_ce) begin
                    errors++;
                    $display("FAIL err_cadence t=%0d k=%0d got %b want %b", t, k, ce, exp_ce);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        cfg_ch    = 4'd0;
        cfg_div   = 8'd4;
        cfg_phase = 8'd0;
        cfg_valid = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            tick();
            checks++;
            if (locked !== lk_held[10-n]) begin
                errors++;
                $display("FAIL held_lock n=%0d got %b want %b", n, locked, lk_held[10-n]);
            end
            if (lk_held[10-n] == 1'b0) begin
                checks++;
                if (ce !== 3'b000) begin
                    errors++;
                    $display("FAIL held_warm_ce n=%0d got %b want 000", n, ce);
                end
            end else if (n == 5) begin
                checks++;
                if (ce !== 3'b011) begin
                    errors++;
                    $display("FAIL held_first_run_ce got %b want 011", ce);
                end
            end
            if (n == 1) begin
                cfg_ch  = 4'd2;
                cfg_div = 8'd1;
            end
            if (n == 6) cfg_valid = 1'b0;
        end
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (ce !== {1'b1, ce1_d5[11-i], ce0_def[11-i]}) begin
                errors++;
                $display("FAIL div1_ce k=%0d got %b want %b", i, ce, {1'b1, ce1_d5[11-i], ce0_def[11-i]});
            end
            checks++;
            if (clk_o !== {1'b1, co1_d5[11-i], co0_def[11-i]}) begin
                errors++;
                $display("FAIL div1_clk_o k=%0d got %b want %b", i, clk_o,
                         {1'b1, co1_d5[11-i], co0_def[11-i]});
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        tick();
        reset_n = 1'b0;
        #1;
        checks++;
        if ({locked, cfg_ready, cfg_err, ce, clk_o} !== 9'b0) begin
            errors++;
            $display("FAIL mid_reset got %b want 000000000", {locked, cfg_ready, cfg_err, ce, clk_o});
        end
        tick();
        reset_n = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            tick();
            checks++;
            if (locked !== (n == 4)) begin
                errors++;
                $display("FAIL mid_relock n=%0d got %b want %b", n, locked, n == 4);
            end
        end
        for (int i = 0; i < 12; i++) begin
            checks++;
            if ({ce, clk_o} !== {ce2_def[11-i], ce1_def[11-i], ce0_def[11-i],
                                 co2_def[11-i], co1_def[11-i], co0_def[11-i]}) begin
                errors++;
                $display("FAIL mid_init_pattern k=%0d got %b want %b", i, {ce, clk_o},
                         {ce2_def[11-i], ce1_def[11-i], ce0_def[11-i],
                          co2_def[11-i], co1_def[11-i], co0_def[11-i]});
            end
            tick();
        end
    endtask

    task automatic test_window();
        int cnt0 = 0;
        int cnt1 = 0;
        int cnt2 = 0;
        int stray = 0;
        for (int i = 0; i < 240; i++) begin
            cnt0 += int'(ce[0]);
            cnt1 += int'(ce[1]);
            cnt2 += int'(ce[2]);
            if (!locked && ce != 3'b000) stray++;
            tick();
        end
        checks++;
        if (cnt0 !== 60) begin errors++; $display("FAIL window_ch0 got %0d want 60", cnt0); end
        checks++;
        if (cnt1 !== 40) begin errors++; $display("FAIL window_ch1 got %0d want 40", cnt1); end
        checks++;
        if (cnt2 !== 30) begin errors++; $display("FAIL window_ch2 got %0d want 30", cnt2); end
        checks++;
        if (stray !== 0) begin errors++; $display("FAIL window_unlocked_ce got %0d want 0", stray); end
    endtask

    initial begin
        test_reset();
        test_default_phases();
        test_reconfig();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        test_window();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
